// File: rtl/aes_inv_sub_bytes.sv
// aes_inv_sub_bytes: AES InvSubBytes over a 128-bit state. The state is processed
// one column per clock through four 8-bit inverse S-boxes, so a result is ready
// 4 clocks after the accepting edge.
// Optional build macro AES_INV_SHIFTROWS_EN folds InvShiftRows into the capture.
// Without the macro the captured state is a straight copy of s_data.
//
// state | meaning
// IDLE  | waiting for a state word (s_ready=1)
// BUSY  | substituting column col, one column per clock
// DONE  | result held on m_data until m_ready

// Inverse S-box: inverse affine transform followed by the GF(2^8) inverse.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] t;

    // Inverse affine map (rotations by 1, 3 and 6, constant 05), then invert.
    always_comb begin
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y = gf_inv(t);
    end

endmodule

module aes_inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            fsm;
    logic [1:0]        col;
    // st[3] holds column 0 (the most significant 32 bits of the state).
    logic [3:0][31:0]  st;
    logic [127:0]      cap;
    logic [31:0]       col_in;
    logic [31:0]       col_out;

    assign m_data = st;

    // Select the column currently being substituted.
    always_comb begin
        col_in = st[2'd3 - col];
    end

    aes_inv_sbox u_sbox0 (.a(col_in[31:24]), .y(col_out[31:24]));
    aes_inv_sbox u_sbox1 (.a(col_in[23:16]), .y(col_out[23:16]));
    aes_inv_sbox u_sbox2 (.a(col_in[15:8]),  .y(col_out[15:8]));
    aes_inv_sbox u_sbox3 (.a(col_in[7:0]),   .y(col_out[7:0]));

`ifdef AES_INV_SHIFTROWS_EN
    // Capture with InvShiftRows: row r is rotated right by r columns.
    always_comb begin
        cap = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                cap[127 - 8*(r + 4*c) -: 8] = s_data[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
    end
`else
    // Capture as a straight copy.
    always_comb begin
        cap = s_data;
    end
`endif

    // Control FSM, column counter, state register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            col     <= 2'd0;
            st      <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else if (flush) begin
            fsm     <= IDLE;
            col     <= 2'd0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (s_valid) begin
                        st      <= cap;
                        col     <= 2'd0;
                        fsm     <= BUSY;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    st[2'd3 - col] <= col_out;
                    col            <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm     <= DONE;
                        m_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        fsm     <= IDLE;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    col     <= 2'd0;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Testbench for aes_inv_sub_bytes: directed vectors plus randomized transfers
// against a table-based reference built from the forward AES S-box definition.
module tb_aes_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] inv_tab [256];

    aes_inv_sub_bytes dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box = affine(inverse); the inverse table is its inversion.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] f;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            f = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tab[f] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] in);
        logic [7:0] bi [16];
        logic [127:0] out = '0;
        for (int i = 0; i < 16; i++) bi[i] = in[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
`ifdef AES_INV_SHIFTROWS_EN
                out[127 - 8*(r + 4*c) -: 8] = inv_tab[bi[r + 4*((c - r + 4) % 4)]];
`else
                out[127 - 8*(r + 4*c) -: 8] = inv_tab[bi[r + 4*c]];
`endif
            end
        end
        return out;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer: accept, check latency and result, optional stall, drain.
    task automatic run_op(input logic [127:0] data, input logic [127:0] exp,
                          input logic pre_ready, input int stall, input string tag);
        int n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".s_ready_idle"}, 128'(s_ready), 128'd1);
        s_valid = 1'b1;
        s_data  = data;
        m_ready = pre_ready;
        tick();
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, ".busy"}, {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b100});
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 128'(n), 128'd4);
        chk({tag, ".data"}, m_data, exp);
        if (!pre_ready) begin
            for (int k = 0; k < stall; k++) begin
                tick();
                chk({tag, ".stall"}, {m_data, 1'b0} | {127'd0, m_valid} | {126'd0, s_ready, 1'b0},
                    {exp, 1'b0} | 129'd1);
            end
            m_ready = 1'b1;
        end
        tick();
        m_ready = 1'b0;
        chk({tag, ".drain"}, {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});
    endtask

    initial begin
        logic [127:0] v;
        int n;
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        build_tables();
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset.ctrl", {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});
        chk("reset.data", m_data, 128'h0);

        run_op(128'h0, {16{8'h52}}, 1'b0, 0, "zero");
        run_op({16{8'h63}}, 128'h0, 1'b0, 0, "all63");
        v = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_INV_SHIFTROWS_EN
        run_op(v, model(v), 1'b0, 0, "seq");
        chk("seq.col0", {96'd0, m_data[127:96]}, 128'h52f3a338);
`else
        run_op(v, 128'h52096ad53036a538bf40a39e81f3d7fb, 1'b0, 0, "seq");
`endif
        run_op(v, model(v), 1'b0, 10, "stall10");
        run_op({16{8'h63}}, 128'h0, 1'b1, 0, "same_cycle_ready");

        // flush beats acceptance in IDLE
        s_valid = 1'b1;
        s_data  = v;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_idle", {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});

        // flush on the second BUSY cycle
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
        tick();
        flush = 1'b1;
        m_ready = 1'b1;
        tick();
        flush = 1'b0;
        m_ready = 1'b0;
        chk("flush_busy", {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m_valid) n++;
        end
        chk("flush_no_valid", 128'(n), 128'd0);
        run_op(128'h0, {16{8'h52}}, 1'b0, 0, "after_flush");

        // reset while in DONE
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rst_done.reach", 128'(m_valid), 128'd1);
        rst_n = 1'b0;
        m_ready = 1'b1;
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        m_ready = 1'b0;
        flush = 1'b0;
        chk("rst_done.ctrl", {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});
        chk("rst_done.data", m_data, 128'h0);

        // reset mid-BUSY discards the partial state
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy.data", m_data, 128'h0);
        chk("rst_busy.ctrl", {125'd0, busy, s_ready, m_valid}, {125'd0, 3'b010});

        for (int k = 0; k < 20; k++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            run_op(v, model(v), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
